// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues sequential word fetches to an in-order, variable-latency memory.
// Returned words are buffered with their next-PC and handed to decode over
// a valid/ready handshake. A redirect flushes the queue and marks every
// outstanding response stale. Fetching stops once an HLT word is enqueued.
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_ir,
  output logic [31:0] out_npc,
  input  logic        out_ready,
  output logic        halted
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [5:0]  HLT_OP  = 6'b111111;

  // Control state
  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] stale;
  logic          stop;
  logic [PW-1:0] af_rd;
  logic [PW-1:0] af_wr;

  // Data storage (never reset; validity is tracked by the control state)
  logic [31:0] q_ir    [DEPTH];
  logic [31:0] q_npc   [DEPTH];
  logic [31:0] af_addr [DEPTH];

  logic        fire;
  logic        enq;
  logic        deq;
  logic [CW:0] credit;

  // Request credit, handshake qualifiers and output valid
  always_comb begin
    // Live occupancy: queued entries plus responses that will be kept.
    credit         = {1'b0, count} + {1'b0, inflight} - {1'b0, stale};
    imem_req_valid = !rst && !stop && !redirect_valid &&
                     (credit < DEPTH_C) && ({1'b0, inflight} < DEPTH_C);
    fire           = imem_req_valid && imem_req_ready;
    enq            = imem_rsp_valid && (stale == '0) && !redirect_valid && !rst;
    out_valid      = !rst && (count != '0) && !redirect_valid;
    deq            = out_valid && out_ready;
  end

  assign imem_req_addr = pc;
  assign out_ir        = q_ir[head];
  assign out_npc       = q_npc[head];
  assign halted        = stop && !rst;

  // Control: pointers, counters, PC and halt flag; redirect overrides all
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
      stop     <= 1'b0;
      af_rd    <= '0;
      af_wr    <= '0;
    end else begin
      // The address FIFO mirrors the in-flight requests, stale or not.
      if (fire)           af_wr <= af_wr + PW'(1);
      if (imem_rsp_valid) af_rd <= af_rd + PW'(1);
      inflight <= inflight + CW'(fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc    <= redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        stop  <= 1'b0;
        // Everything still outstanding after this cycle belongs to the old path.
        stale <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (fire)                             pc    <= pc + 32'd1;
        if (imem_rsp_valid && stale != '0)    stale <= stale - CW'(1);
        if (enq)                              tail  <= tail + PW'(1);
        if (deq)                              head  <= head + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
        if (enq && imem_rsp_data[31:26] == HLT_OP) stop <= 1'b1;
      end
    end
  end

  // Data: remember each request address, store kept words with their next-PC
  always_ff @(posedge clk1) begin
    if (fire) af_addr[af_wr] <= pc;
    if (enq) begin
      q_ir[tail]  <= imem_rsp_data;
      q_npc[tail] <= af_addr[af_rd] + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: an in-order variable-latency memory model,
// a queue-level reference of the fetch path, per-cycle output comparison and
// directed scenarios with hand-computed literal expectations.
module tb_mips32_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] NO_HLT   = 32'hFFFF_FFFF;

  logic        clk1;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
  logic        out_ready;
  logic        halted;

  mips32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk1           (clk1),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ir         (out_ir),
    .out_npc        (out_npc),
    .out_ready      (out_ready),
    .halted         (halted)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  // Memory model and reference fetch path
  req_t        pend[$];
  ent_t        mq[$];
  int          epoch;
  int          cyc;
  logic [31:0] exp_addr;
  bit          mstop;
  int          lat;
  logic [31:0] hlt_addr;

  // Scenario bookkeeping
  int          checks;
  int          errors;
  int          fires;
  logic [31:0] last_fire_addr;
  logic [31:0] del_ir[$];
  logic [31:0] del_npc[$];
  int          first_del_cyc;

  // Values sampled in the most recent tick
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_out_valid;
  logic [31:0] s_out_ir;
  logic        s_rsp_valid;
  logic        s_halted;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == hlt_addr) return {6'b111111, a[25:0]};
    return a;
  endfunction

  function automatic int live_pending();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: present memory response, compare outputs, advance model.
  task automatic tick();
    bit   e_req, e_out, rsp_s, fire_s, deq_s, live;
    req_t r;
    ent_t e;
    int   due;
    rsp_s          = !rst && pend.size() > 0 && pend[0].due <= cyc;
    imem_rsp_valid = rsp_s;
    imem_rsp_data  = rsp_s ? mem_word(pend[0].addr) : 32'h0;
    #1;
    e_req = !rst && !mstop && !redirect_valid &&
            (mq.size() + live_pending()) < DEPTH && pend.size() < DEPTH;
    e_out = !rst && !redirect_valid && mq.size() > 0;
    chk("req_valid", imem_req_valid, e_req);
    if (e_req) chk("req_addr", imem_req_addr, exp_addr);
    chk("out_valid", out_valid, e_out);
    if (e_out) begin
      chk("out_ir", out_ir, mq[0].ir);
      chk("out_npc", out_npc, mq[0].npc);
    end
    chk("halted", halted, !rst && mstop);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_out_ir    = out_ir;
    s_rsp_valid = imem_rsp_valid;
    s_halted    = halted;
    fire_s = e_req && imem_req_ready;
    deq_s  = e_out && out_ready;
    live   = rsp_s && !rst && !redirect_valid && pend[0].epoch == epoch;
    if (live) chk("credit_room", (mq.size() - (deq_s ? 1 : 0)) < DEPTH, 1'b1);
    @(posedge clk1);
    if (rst) begin
      pend.delete();
      mq.delete();
      epoch++;
      exp_addr = RESET_PC;
      mstop    = 1'b0;
    end else if (redirect_valid) begin
      if (rsp_s) r = pend.pop_front();
      mq.delete();
      epoch++;
      exp_addr = redirect_pc;
      mstop    = 1'b0;
    end else begin
      if (deq_s) begin
        e = mq.pop_front();
        del_ir.push_back(e.ir);
        del_npc.push_back(e.npc);
        if (first_del_cyc < 0) first_del_cyc = cyc;
      end
      if (rsp_s) begin
        r = pend.pop_front();
        if (r.epoch == epoch) begin
          e.ir  = mem_word(r.addr);
          e.npc = r.addr + 32'd1;
          mq.push_back(e);
          if (e.ir[31:26] == 6'b111111) mstop = 1'b1;
        end
      end
      if (fire_s) begin
        due = cyc + lat;
        if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
        r.addr  = exp_addr;
        r.epoch = epoch;
        r.due   = due;
        pend.push_back(r);
        last_fire_addr = exp_addr;
        exp_addr       = exp_addr + 32'd1;
        fires++;
      end
    end
    cyc++;
    @(negedge clk1);
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) tick();
    rst            = 1'b0;
    cyc            = 0;
    fires          = 0;
    first_del_cyc  = -1;
    last_fire_addr = 32'h0;
    del_ir.delete();
    del_npc.delete();
  endtask

  initial begin
    checks = 0; errors = 0; epoch = 0; cyc = 0; mstop = 1'b0;
    exp_addr = RESET_PC; lat = 1; hlt_addr = NO_HLT;
    fires = 0; first_del_cyc = -1; last_fire_addr = 32'h0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    out_ready = 1'b1;
    @(negedge clk1);

    // Reset state and streaming with a 1-cycle memory
    do_reset(2);
    chk("reset_req_valid", s_req_valid, 1'b0);
    chk("reset_out_valid", s_out_valid, 1'b0);
    chk("reset_halted", s_halted, 1'b0);
    repeat (12) tick();
    chk("stream_first_cycle", first_del_cyc, 32'd2);
    chk("stream_count", del_ir.size(), 32'd10);
    if (del_ir.size() == 10) begin
      chk("stream_ir0", del_ir[0], 32'd0);
      chk("stream_ir9", del_ir[9], 32'd9);
      chk("stream_npc9", del_npc[9], 32'd10);
    end

    // Back-pressure fills exactly DEPTH entries, then drains in order
    out_ready = 1'b0;
    do_reset(1);
    repeat (10) tick();
    chk("bp_fires", fires, 32'd4);
    chk("bp_head_valid", s_out_valid, 1'b1);
    chk("bp_head_ir", s_out_ir, 32'd0);
    out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drained_enough", del_ir.size() >= 4, 1'b1);
    if (del_ir.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("bp_order", del_ir[i], i);
    end

    // Redirect with three requests in flight on a 3-cycle memory
    lat = 3;
    do_reset(1);
    repeat (3) tick();
    chk("rd_no_early_delivery", del_ir.size(), 32'd0);
    chk("rd_inflight", fires, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'd100;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    chk("rd_first_cycle", first_del_cyc, 32'd8);
    if (del_ir.size() > 0) begin
      chk("rd_first_ir", del_ir[0], 32'd100);
      chk("rd_first_npc", del_npc[0], 32'd101);
    end else chk("rd_delivered", 32'd0, 32'd1);

    // Redirect coincident with a response and a possible dequeue
    lat = 1;
    do_reset(1);
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'd200;
    tick();
    redirect_valid = 1'b0;
    chk("rc_rsp_present", s_rsp_valid, 1'b1);
    chk("rc_no_deq", s_out_valid, 1'b0);
    chk("rc_no_req", s_req_valid, 1'b0);
    tick();
    chk("rc_empty_next", s_out_valid, 1'b0);
    chk("rc_req_next", s_req_valid, 1'b1);
    chk("rc_req_addr", s_req_addr, 32'd200);
    tick();
    tick();
    chk("rc_out_r3", s_out_valid, 1'b1);
    chk("rc_out_ir", s_out_ir, 32'd200);

    // HLT at address 5 stops fetching; redirect to 0 resumes
    hlt_addr = 32'd5;
    do_reset(1);
    repeat (15) tick();
    chk("hlt_halted", s_halted, 1'b1);
    chk("hlt_last_addr", last_fire_addr, 32'd6);
    chk("hlt_fires", fires, 32'd7);
    chk("hlt_delivered", del_ir.size(), 32'd7);
    if (del_ir.size() == 7) chk("hlt_word", del_ir[5], 32'hFC00_0005);
    hlt_addr = NO_HLT;
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    chk("hlt_still_in_redirect", s_halted, 1'b1);
    tick();
    chk("hlt_cleared", s_halted, 1'b0);
    chk("hlt_resume_req", s_req_valid, 1'b1);
    chk("hlt_resume_addr", s_req_addr, 32'd0);
    repeat (4) tick();

    // Random ready / latency / redirect soak with one mid-run reset
    hlt_addr = 32'd37;
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 10) < 7;
      lat            = $urandom_range(1, 4);
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc    = $urandom_range(0, 60);
      rst            = (i == 1500);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    chk("soak_progress", del_ir.size() > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
